// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the core front end.
package riscv_pkg;

  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [31:0] BUBBLE_INS = 32'h0;

  typedef struct packed {
    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries; flush wins over push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         Rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 wdata_i,
  output fetch_entry_t                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A push into a full FIFO is only accepted when a pop frees the slot.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (Rst || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem via req/gnt/rvalid,
// buffers responses and drives the IF/ID register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W     = riscv_pkg::ADDR_W,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = riscv_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              debug,
  input  logic              hz,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branoff,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] IF_ID_pres_adr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic              out_q, out_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;
  logic              req_q, req_d;
  logic              started_q;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] pres_q, pres_d;

  fetch_entry_t      push_entry, head;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              fifo_empty, fifo_full;
  logic              issue_ok, fire, redirect, rsp, push, pop;

  // Outstanding response reserves a slot so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, out_q};
  assign issue_ok  = started_q && !debug && !out_q && !branch_taken &&
                     !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));

  // A request seen at an edge without grant is held until granted.
  assign imem_req  = req_q || issue_ok;
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_gnt;
  assign redirect  = branch_taken && !debug;
  assign rsp       = imem_rvalid && out_q;
  assign push      = rsp && (req_epoch_q == epoch_q);
  assign pop       = !debug && !branch_taken && !hz && !fifo_empty;

  assign push_entry = '{ins: imem_rdata, pc: infl_addr_q};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .Rst     (Rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (push_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    pc_d        = pc_q;
    infl_addr_d = infl_addr_q;
    out_d       = out_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    req_d       = imem_req && !imem_gnt && !redirect;
    ins_d       = ins_q;
    pres_d      = pres_q;

    if (rsp) out_d = 1'b0;
    if (fire) begin
      out_d       = 1'b1;
      req_epoch_d = epoch_q;
      infl_addr_d = pc_q;
      pc_d        = pc_q + ADDR_W'(4);
    end
    // A grant coinciding with a redirect stays tagged with the old epoch.
    if (redirect) begin
      pc_d    = branoff & ~ADDR_W'(3);
      epoch_d = ~epoch_q;
    end

    if (debug) begin
      ins_d = ins_q;
    end else if (branch_taken) begin
      ins_d = BUBBLE_INS;
    end else if (hz) begin
      ins_d = ins_q;
    end else if (!fifo_empty) begin
      ins_d  = head.ins;
      pres_d = head.pc;
    end else begin
      ins_d = BUBBLE_INS;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      pc_q        <= RESET_PC;
      out_q       <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      req_q       <= 1'b0;
      started_q   <= 1'b0;
      ins_q       <= BUBBLE_INS;
      pres_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      req_q       <= req_d;
      started_q   <= 1'b1;
      ins_q       <= ins_d;
      pres_q      <= pres_d;
    end
  end

  always_ff @(posedge clk) begin
    infl_addr_q <= infl_addr_d;
  end

  assign ins            = ins_q;
  assign IF_ID_pres_adr = pres_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple fixed-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        Rst, debug, hz, branch_taken;
  logic [7:0]  branoff;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, ins;
  logic [7:0]  pres;

  int          errs = 0;
  int          checks = 0;
  int          lat;
  logic        fire, ld, v1;
  logic [7:0]  faddr, a1;
  logic [31:0] iq_ins[$];
  logic [7:0]  iq_pc[$];
  logic [7:0]  gq[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .Rst            (Rst),
    .debug          (debug),
    .hz             (hz),
    .branch_taken   (branch_taken),
    .branoff        (branoff),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ins            (ins),
    .IF_ID_pres_adr (pres)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: log grants and IF/ID loads, then play the memory response.
  task automatic tick();
    #1;
    fire  = imem_req & imem_gnt;
    faddr = imem_addr;
    ld    = !Rst && !debug && !branch_taken && !hz;
    if (fire) gq.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (ld && ins != 32'h0) begin
      iq_ins.push_back(ins);
      iq_pc.push_back(pres);
    end
    case (lat)
      1: begin
        imem_rvalid = fire;
        imem_rdata  = {24'h0, faddr} + 32'h100;
        v1 = 1'b0;
      end
      2: begin
        imem_rvalid = v1;
        imem_rdata  = {24'h0, a1} + 32'h100;
        v1 = fire;
        a1 = faddr;
      end
      default: begin
        imem_rvalid = 1'b0;
        v1 = 1'b0;
      end
    endcase
  endtask

  task automatic reset_dut();
    Rst = 1'b1; debug = 1'b0; hz = 1'b0; branch_taken = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    iq_ins.delete(); iq_pc.delete(); gq.delete();
  endtask

  initial begin
    Rst = 1'b1; debug = 1'b0; hz = 1'b0; branch_taken = 1'b0; branoff = 8'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    lat = 1; v1 = 1'b0; a1 = 8'h0;

    // Basic stream
    reset_dut();
    chk("t1_req_rst", imem_req, 0);
    chk("t1_ins_rst", ins, 0);
    chk("t1_pc_rst", pres, 0);
    tick();
    chk("t1_ins_e1", ins, 0);
    chk("t1_req_e1", imem_req, 1);
    chk("t1_addr_e1", imem_addr, 8'h00);
    tick(); tick();
    chk("t1_prefill", ins, 0);
    tick();
    chk("t1_ins0", ins, 32'h100); chk("t1_pc0", pres, 8'h00);
    tick(); tick();
    chk("t1_ins1", ins, 32'h104); chk("t1_pc1", pres, 8'h04);
    tick(); tick();
    chk("t1_ins2", ins, 32'h108); chk("t1_pc2", pres, 8'h08);
    chk("t1_gcnt", gq.size(), 4);
    chk("t1_g0", gq[0], 8'h00); chk("t1_g1", gq[1], 8'h04);
    chk("t1_g2", gq[2], 8'h08); chk("t1_g3", gq[3], 8'h0C);

    // Hazard hold
    hz = 1'b1;
    tick();
    chk("t2_hold_e9", ins, 32'h108);
    tick(); tick();
    chk("t2_hold_ins", ins, 32'h108);
    chk("t2_hold_pc", pres, 8'h08);
    chk("t2_req_full", imem_req, 0);
    hz = 1'b0;
    tick();
    chk("t2_ins_a", ins, 32'h10C); chk("t2_pc_a", pres, 8'h0C);
    tick();
    chk("t2_ins_b", ins, 32'h110); chk("t2_pc_b", pres, 8'h10);

    // Redirect with a granted response still in flight
    lat = 1;
    reset_dut();
    for (int i = 0; i < 7; i++) tick();
    lat = 2;
    tick();
    chk("t3_pre_ins", ins, 32'h108);
    branch_taken = 1'b1; branoff = 8'h43;
    tick();
    branch_taken = 1'b0;
    chk("t3_bubble", ins, 0);
    chk("t3_pc_held", pres, 8'h08);
    chk("t3_req_busy", imem_req, 0);
    tick();
    chk("t3_drop_ins", ins, 0);
    chk("t3_req_new", imem_req, 1);
    chk("t3_addr_new", imem_addr, 8'h40);
    for (int i = 0; i < 4; i++) tick();
    chk("t3_ins_tgt", ins, 32'h140);
    chk("t3_pc_tgt", pres, 8'h40);
    chk("t3_qcnt", iq_ins.size(), 4);
    chk("t3_q3_ins", iq_ins[3], 32'h140);
    chk("t3_q3_pc", iq_pc[3], 8'h40);

    // Address wrap
    lat = 1;
    reset_dut();
    branch_taken = 1'b1; branoff = 8'hFC;
    tick();
    branch_taken = 1'b0;
    chk("t4_addr_fc", imem_addr, 8'hFC);
    tick(); tick();
    chk("t4_addr_wrap", imem_addr, 8'h00);
    chk("t4_req_wrap", imem_req, 1);
    tick();
    chk("t4_ins_fc", ins, 32'h1FC); chk("t4_pc_fc", pres, 8'hFC);
    tick(); tick();
    chk("t4_ins_00", ins, 32'h100); chk("t4_pc_00", pres, 8'h00);

    // Debug freeze with a response in flight
    debug = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_frz_ins", ins, 32'h100);
      chk("t5_frz_pc", pres, 8'h00);
      chk("t5_frz_req", imem_req, 0);
    end
    debug = 1'b0;
    lat = 0;
    tick();
    chk("t5_ins_after", ins, 32'h104);
    chk("t5_pc_after", pres, 8'h04);
    chk("t5_qcnt", iq_ins.size(), 3);
    chk("t5_q0", iq_ins[0], 32'h1FC);
    chk("t5_q1", iq_ins[1], 32'h100);
    chk("t5_q2", iq_ins[2], 32'h104);

    // Reset while a request is outstanding, stray response afterwards
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("t6_ins_rst", ins, 0);
    chk("t6_pc_rst", pres, 0);
    chk("t6_req_rst", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("t6_addr0", imem_addr, 8'h00);
    chk("t6_req1", imem_req, 1);
    lat = 1;
    tick();
    chk("t6_empty_a", ins, 0);
    tick();
    chk("t6_empty_b", ins, 0);
    tick();
    chk("t6_ins_first", ins, 32'h100);
    chk("t6_pc_first", pres, 8'h00);

    // Ungranted request held through debug, withdrawn by redirect
    reset_dut();
    imem_gnt = 1'b0;
    tick(); tick();
    debug = 1'b1;
    chk("t7_req_dbg", imem_req, 1);
    tick();
    chk("t7_req_held", imem_req, 1);
    chk("t7_addr_held", imem_addr, 8'h00);
    debug = 1'b0;
    branch_taken = 1'b1; branoff = 8'h20;
    tick();
    branch_taken = 1'b0;
    chk("t7_addr_redir", imem_addr, 8'h20);
    imem_gnt = 1'b1;
    tick();
    chk("t7_gcnt", gq.size(), 1);
    chk("t7_g0", gq[0], 8'h20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
